// File: rtl/omega_ramp_ctrl.sv
// Slew-rate-limited omega sequencer for three_phase_shape: ramp, hold, soft stop, emergency stop.
// Optional zero-crossing dwell is enabled by defining ZERO_DWELL_EN.
module omega_ramp_ctrl #(
  parameter int unsigned OMEGA_BW  = 16,
  parameter int unsigned STEP_BW   = 16,
  parameter int unsigned DIV_BW    = 16,
  parameter int unsigned DWELL_CYC = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       estop,
  input  logic signed [OMEGA_BW-1:0] target_omega,
  input  logic        [STEP_BW-1:0]  step,
  input  logic        [DIV_BW-1:0]   tick_div,
  output logic signed [OMEGA_BW-1:0] omega,
  output logic                       at_target,
  output logic                       busy,
  output logic                       fault,
  output logic        [1:0]          state
);

  localparam int unsigned XW = OMEGA_BW + 1;
  localparam int unsigned AW = (STEP_BW > XW) ? STEP_BW : XW;

  typedef enum logic [2:0] {StIdle, StRamp, StHold, StStop, StFault} state_e;

  state_e                     state_q, state_d;
  logic signed [OMEGA_BW-1:0] omega_q, omega_d;
  logic        [DIV_BW-1:0]   cnt_q, cnt_d;
  logic        [1:0]          state_code;

  logic signed [OMEGA_BW-1:0] omega_max, omega_min, tgt, omega_nxt;
  logic signed [XW-1:0]       omega_ext, goal, diff, upd;
  logic        [XW-1:0]       diff_abs, mag_x;
  logic        [AW-1:0]       step_eff, mag;
  logic                       tick, dwell_act, running;

  // Most-negative target is folded in so omega stays symmetric about zero.
  assign omega_max = {1'b0, {(OMEGA_BW-1){1'b1}}};
  assign omega_min = {1'b1, {(OMEGA_BW-1){1'b0}}};
  assign tgt       = (target_omega == omega_min) ? -omega_max : target_omega;

`ifdef ZERO_DWELL_EN
  localparam int unsigned DW = $clog2(DWELL_CYC + 2);
  logic [DW-1:0] dwell_q, dwell_d;
  logic          cross;
  assign dwell_act = (dwell_q != '0);
`else
  assign dwell_act = 1'b0;
`endif

  assign running = (state_q == StRamp) || (state_q == StStop);
  assign tick    = running && (cnt_q == tick_div) && !dwell_act;

  // Update arithmetic in one extra bit so diff never wraps.
  always_comb begin
    omega_ext = {omega_q[OMEGA_BW-1], omega_q};
    goal      = (state_q == StRamp) ? {tgt[OMEGA_BW-1], tgt} : '0;
    diff      = goal - omega_ext;
    diff_abs  = diff[XW-1] ? $unsigned(-diff) : $unsigned(diff);
    step_eff  = AW'(step);
    if ((state_q == StStop) && (step == '0)) step_eff = AW'(1);
    mag       = (AW'(diff_abs) < step_eff) ? AW'(diff_abs) : step_eff;
    mag_x     = mag[XW-1:0];
    upd       = diff[XW-1] ? (omega_ext - $signed(mag_x)) : (omega_ext + $signed(mag_x));
    omega_nxt = upd[OMEGA_BW-1:0];
  end

  always_comb begin
    state_d = state_q;
    omega_d = omega_q;
    cnt_d   = '0;
`ifdef ZERO_DWELL_EN
    dwell_d = '0;
    cross   = (omega_q != '0) && (omega_nxt != '0) &&
              (omega_nxt[OMEGA_BW-1] != omega_q[OMEGA_BW-1]);
`endif
    if (estop) begin
      state_d = StFault;
      omega_d = '0;
    end else begin
      unique case (state_q)
        StIdle: if (enable) state_d = StRamp;
        StRamp: begin
          if (!enable) begin
            state_d = StStop;
          end else begin
`ifdef ZERO_DWELL_EN
            if (dwell_act) begin
              dwell_d = dwell_q - 1'b1;
            end else if (tick && cross) begin
              omega_d = '0;
              dwell_d = DW'(DWELL_CYC);
            end else if (tick) begin
              omega_d = omega_nxt;
            end
`else
            if (tick) omega_d = omega_nxt;
`endif
            if (omega_d == tgt) state_d = StHold;
          end
        end
        StHold: begin
          if (!enable)              state_d = StStop;
          else if (tgt != omega_q)  state_d = StRamp;
        end
        StStop: begin
          if (enable) begin
            state_d = StRamp;
          end else begin
            if (tick) omega_d = omega_nxt;
            if (omega_d == '0) state_d = StIdle;
          end
        end
        StFault: if (!enable) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // Counter only advances while staying in RAMP/STOP; any entry restarts it.
    if (running && (state_d == state_q) && !dwell_act && !tick) cnt_d = cnt_q + 1'b1;
`ifdef ZERO_DWELL_EN
    if (state_d != StRamp) dwell_d = '0;
`endif
  end

  always_comb begin
    case (state_d)
      StRamp:           state_code = 2'd1;
      StHold:           state_code = 2'd2;
      StStop, StFault:  state_code = 2'd3;
      default:          state_code = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      omega_q   <= '0;
      cnt_q     <= '0;
      at_target <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      state     <= 2'd0;
`ifdef ZERO_DWELL_EN
      dwell_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      omega_q   <= omega_d;
      cnt_q     <= cnt_d;
      at_target <= (state_d == StHold);
      busy      <= (state_d == StRamp) || (state_d == StStop);
      fault     <= (state_d == StFault);
      state     <= state_code;
`ifdef ZERO_DWELL_EN
      dwell_q   <= dwell_d;
`endif
    end
  end

  assign omega = omega_q;

endmodule

// File: tb/tb_omega_ramp_ctrl.sv
// Self-checking bench for omega_ramp_ctrl: integer reference model checked every cycle,
// plus directed literal expectations; covers ZERO_DWELL_EN when the macro is defined.
module tb_omega_ramp_ctrl;

  localparam int OBW   = 16;
  localparam int DWELL = 8;
  localparam int OMAX  = (1 << (OBW - 1)) - 1;
  localparam int OMIN  = -(1 << (OBW - 1));

  localparam int MIDLE  = 0;
  localparam int MRAMP  = 1;
  localparam int MHOLD  = 2;
  localparam int MSTOP  = 3;
  localparam int MFAULT = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  estop = 1'b0;
  logic signed [OBW-1:0] target_omega = '0;
  logic        [15:0]    step = '0;
  logic        [15:0]    tick_div = '0;
  logic signed [OBW-1:0] omega;
  logic                  at_target, busy, fault;
  logic        [1:0]     state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_mode = MIDLE;
  int m_omega = 0;
  int m_cnt = 0;
  int m_dwell = 0;

  omega_ramp_ctrl #(
    .OMEGA_BW (OBW),
    .STEP_BW  (16),
    .DIV_BW   (16),
    .DWELL_CYC(DWELL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .estop       (estop),
    .target_omega(target_omega),
    .step        (step),
    .tick_div    (tick_div),
    .omega       (omega),
    .at_target   (at_target),
    .busy        (busy),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the ramp rules.
  always @(posedge clk) begin : model
    int t, goal, diff, adiff, stp, mag, nxt, prev, dw_was;
    bit tick;
    t      = (int'(target_omega) == OMIN) ? -OMAX : int'(target_omega);
    prev   = m_mode;
    dw_was = m_dwell;
    tick   = ((m_mode == MRAMP) || (m_mode == MSTOP)) && (m_cnt == int'(tick_div)) &&
             (m_dwell == 0);
    goal   = (m_mode == MRAMP) ? t : 0;
    diff   = goal - m_omega;
    adiff  = (diff < 0) ? -diff : diff;
    stp    = ((m_mode == MSTOP) && (step == 0)) ? 1 : int'(step);
    mag    = (adiff < stp) ? adiff : stp;
    nxt    = (diff < 0) ? m_omega - mag : m_omega + mag;
    if (rst) begin
      m_mode = MIDLE; m_omega = 0; m_dwell = 0;
    end else if (estop) begin
      m_mode = MFAULT; m_omega = 0; m_dwell = 0;
    end else begin
      case (m_mode)
        MIDLE: if (enable) m_mode = MRAMP;
        MRAMP: begin
          if (!enable) begin
            m_mode = MSTOP; m_dwell = 0;
          end else begin
            if (m_dwell > 0) m_dwell--;
            else if (tick) begin
`ifdef ZERO_DWELL_EN
              if (m_omega != 0 && nxt != 0 && ((m_omega < 0) != (nxt < 0))) begin
                nxt = 0; m_dwell = DWELL;
              end
`endif
              m_omega = nxt;
            end
            if (m_omega == t) begin m_mode = MHOLD; m_dwell = 0; end
          end
        end
        MHOLD: begin
          if (!enable) m_mode = MSTOP;
          else if (t != m_omega) m_mode = MRAMP;
        end
        MSTOP: begin
          if (enable) m_mode = MRAMP;
          else begin
            if (tick) m_omega = nxt;
            if (m_omega == 0) m_mode = MIDLE;
          end
        end
        default: if (!enable) m_mode = MIDLE;
      endcase
    end
    if (m_mode != prev || !(m_mode == MRAMP || m_mode == MSTOP) || dw_was > 0 || tick)
      m_cnt = 0;
    else
      m_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("omega",     int'(omega), m_omega);
      chk("state",     int'(state), (m_mode == MFAULT) ? 3 : m_mode);
      chk("at_target", int'(at_target), int'(m_mode == MHOLD));
      chk("busy",      int'(busy), int'(m_mode == MRAMP || m_mode == MSTOP));
      chk("fault",     int'(fault), int'(m_mode == MFAULT));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_n(2);
    chk_en = 1'b1;
    chk("rst_omega", int'(omega), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_busy",  int'(busy), 0);

    // Basic ramp to 100, step 10, update every 5 cycles.
    rst = 1'b0; enable = 1'b1; target_omega = 100; step = 10; tick_div = 4;
    wait_n(5);
    chk("ramp_pre_tick", int'(omega), 0);
    chk("ramp_state",    int'(state), 1);
    wait_n(1);
    chk("ramp_first",    int'(omega), 10);
    wait_n(45);
    chk("ramp_end",      int'(omega), 100);
    chk("ramp_hold",     int'(at_target), 1);

    // No overshoot: 100 -> 105 -> 107.
    target_omega = 107; step = 5;
    wait_n(6);
    chk("clamp_105", int'(omega), 105);
    wait_n(5);
    chk("clamp_107", int'(omega), 107);
    chk("clamp_hold", int'(state), 2);

    // Most-negative target folds to -OMAX.
    target_omega = 16'sh8000; step = 16'hFFFF; tick_div = 0;
    wait_n(2);
    chk("minclamp_omega", int'(omega), -OMAX);
    chk("minclamp_hold",  int'(state), 2);
    target_omega = 100;
    wait_n(2);
    chk("back_100", int'(omega), 100);

    // Soft stop with step=0 decays by 1 per tick.
    enable = 1'b0; step = 0;
    wait_n(1);
    chk("stop_state", int'(state), 3);
    wait_n(1);
    chk("stop_99", int'(omega), 99);
    wait_n(99);
    chk("stop_zero", int'(omega), 0);
    chk("stop_idle", int'(state), 0);
    chk("stop_busy", int'(busy), 0);

    // Emergency stop mid-ramp.
    enable = 1'b1; target_omega = 100; step = 10; tick_div = 0;
    wait_n(5);
    chk("estop_pre", int'(omega), 40);
    estop = 1'b1;
    wait_n(1);
    chk("estop_omega", int'(omega), 0);
    chk("estop_fault", int'(fault), 1);
    estop = 1'b0;
    wait_n(3);
    chk("fault_sticky", int'(fault), 1);
    enable = 1'b0;
    wait_n(1);
    chk("fault_idle", int'(state), 0);

    // Direction reversal 2 -> -10 with step 5.
    enable = 1'b1; target_omega = 2; step = 5;
    wait_n(2);
    chk("rev_start", int'(omega), 2);
    target_omega = -10;
    wait_n(2);
`ifdef ZERO_DWELL_EN
    chk("rev_clamp0", int'(omega), 0);
    wait_n(DWELL);
    chk("rev_dwell",  int'(omega), 0);
    chk("rev_dwell_busy", int'(busy), 1);
    wait_n(1);
    chk("rev_m5",     int'(omega), -5);
`else
    chk("rev_m3", int'(omega), -3);
    wait_n(1);
    chk("rev_m8", int'(omega), -8);
`endif
    wait_n(1);
    chk("rev_m10",  int'(omega), -10);
    chk("rev_hold", int'(state), 2);

    // Reset mid-ramp, then re-entry with enable still high.
    target_omega = 100; step = 10;
    wait_n(8);
    chk("rst_pre", int'(omega), 60);
    rst = 1'b1;
    wait_n(1);
    chk("rst_mid_omega", int'(omega), 0);
    chk("rst_mid_state", int'(state), 0);
    rst = 1'b0;
    wait_n(1);
    chk("rst_reenter", int'(state), 1);
    wait_n(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/omega_ramp_ctrl.md
Name: omega_ramp_ctrl

Overview:
- Slew-rate-limited sequencer that drives the signed `omega` input of three_phase_shape.
- Ramps `omega` toward a commanded target at a programmable step and tick rate.
- Handles soft stop, direction reversal and emergency stop.
- Prevents step changes in electrical frequency from reaching the sigma-delta/PWM chain.

Parameters:
- OMEGA_BW, 16, width of signed omega (must match three_phase_shape OMEGA_BW)
- STEP_BW, 16, width of unsigned ramp step
- DIV_BW, 16, width of tick prescaler value
- DWELL_CYC, 1000, zero-crossing dwell in clk cycles (used only with ZERO_DWELL_EN)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- enable  input  1  run request; 1 = ramp to target, 0 = ramp to zero
- estop  input  1  emergency stop, highest priority
- target_omega  input  OMEGA_BW signed  commanded omega, sampled every cycle
- step  input  STEP_BW unsigned  max |omega| change per tick
- tick_div  input  DIV_BW unsigned  one update tick every tick_div+1 cycles
- omega  output  OMEGA_BW signed  registered omega to three_phase_shape
- at_target  output  1  high in HOLD
- busy  output  1  high in RAMP or STOP
- fault  output  1  high in FAULT
- state  output  2  IDLE=0, RAMP=1, HOLD=2, STOP=3 (FAULT reported as 3 with fault=1)

Behaviour:
- Reset:
  - state=IDLE, omega=0, tick counter=0.
  - at_target=0, busy=0, fault=0.
  - Reset mid-ramp zeroes omega on the next edge; no soft stop.
- Target clamp: target_omega = -2^(OMEGA_BW-1) is treated as -(2^(OMEGA_BW-1)-1), so omega stays symmetric.
- Tick counter:
  - Runs only in RAMP and STOP; cleared in all other states and on every state entry.
  - tick asserts for one cycle when count==tick_div, then count returns to 0.
  - First update therefore lands tick_div+1 cycles after entering RAMP/STOP.
  - tick_div=0 gives an update every cycle.
- Update arithmetic:
  - Computed in OMEGA_BW+1 bits. diff = goal - omega; goal is target (RAMP) or 0 (STOP).
  - On a tick: omega += sign(diff) * min(step, |diff|).
  - No overshoot, no wrap.
- Transitions, priority top-down, evaluated every edge:
  - Any state, estop=1 → FAULT; omega=0 on the same edge.
  - FAULT → IDLE when estop=0 and enable=0. Stays in FAULT while enable=1, so restart requires deasserting enable.
  - IDLE → RAMP when enable=1. omega stays 0.
  - RAMP → STOP when enable=0.
  - RAMP → HOLD on the edge where next omega == target, including a target change that equals the current omega with no tick.
  - HOLD → STOP when enable=0.
  - HOLD → RAMP when target != omega; counter restarts.
  - STOP → RAMP when enable=1.
  - STOP → IDLE on the edge where next omega == 0.
- step=0:
  - In RAMP, omega freezes; remains busy.
  - In STOP, effective step is 1, so a stop always completes.
- Direction reversal with the macro undefined: a single update may cross zero. Example: omega=2, target=-10, step=5 → -3.
- Outputs:
  - All outputs are registered.
  - at_target, busy, fault and state reflect the state after the edge.
  - omega changes only on ticks, state entry to FAULT, or reset.

Optional Feature:
- Macro: ZERO_DWELL_EN.
- When defined:
  - Any update that would change the sign of omega (in either direction, RAMP or STOP excluded since goal 0 never crosses) clamps omega to exactly 0.
  - The block then holds 0 for DWELL_CYC cycles before continuing toward the target.
  - The dwell counter is internal and counts cycles, not ticks. The tick counter is held at 0 during dwell.
  - State stays RAMP and busy=1 during dwell.
  - enable=0 during dwell → STOP, then IDLE on the next edge (omega already 0).
  - estop during dwell → FAULT.
- When undefined: no dwell logic is synthesised and zero crossing is unrestricted.

Test Plan:
- rst, then enable=1, target=100, step=10, tick_div=4:
  - omega steps 0,10,…,100, one step every 5 cycles, first step 5 cycles after RAMP entry.
  - HOLD and at_target=1 on the edge omega reaches 100.
- Clamp/no overshoot, from HOLD at 100: target=107, step=5 → omega goes 105, then 107, then HOLD. target=-32768 is treated as -32767.
- Soft stop: from omega=100, enable=0, step=0 → STOP; omega decrements by 1 per tick to 0, then IDLE, busy=0.
- estop mid-ramp at omega=40 → next edge omega=0, fault=1. Holding enable=1 with estop=0 stays in FAULT; enable=0 → IDLE.
- Reversal: omega=2, target=-10, step=5, tick_div=0.
  - Macro off: -3, -8, -10.
  - With ZERO_DWELL_EN, DWELL_CYC=8: 0, held 8 cycles, then -5, -10.
- Reset asserted mid-RAMP at omega=60 → omega=0, state=IDLE on that edge. With enable still high, re-enters RAMP after rst drops.
